// File: rtl/two_op_dma.sv
// two_op_dma: block-copy engine mastering the two_op_memory data port, memmove-safe
module two_op_dma #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [ADDR_W-1:0] len,
    output logic              busy,
    output logic              done,
    output logic              bus_req,
    input  logic              bus_gnt,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] d_addr,
    inout  wire  [DATA_W-1:0] d_bus
);
    typedef enum logic [2:0] {IDLE, REQ, RD_A, RD_D, WR, DONE} state_t;

    state_t            state, nxt;
    logic [ADDR_W-1:0] sp, dp, cnt;
    logic [DATA_W-1:0] data_r;
    logic              back;
    logic [ADDR_W-1:0] diff, step;
    logic              bwd;

    // copy backward when the destination starts inside the source block
    assign diff = dst - src;
    assign bwd  = (diff != '0) && (diff < len);
    assign step = back ? {ADDR_W{1'b1}} : ADDR_W'(1);

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= nxt;
    end

    // next-state logic; a zero-length command completes without touching the bus
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (start) nxt = (len != '0) ? REQ : DONE;
            REQ:     if (bus_gnt) nxt = RD_A;
            RD_A:    nxt = RD_D;
            RD_D:    nxt = WR;
            WR:      nxt = (cnt == ADDR_W'(1)) ? DONE : RD_A;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Moore outputs decoded from state and the pointer registers
    always_comb begin
        busy      = state != IDLE;
        done      = state == DONE;
        bus_req   = (state == REQ) || (state == RD_A) || (state == RD_D) || (state == WR);
        mem_read  = (state == RD_A) || (state == RD_D);
        mem_write = state == WR;
        d_addr    = (state == WR) ? dp : ((state == RD_A) || (state == RD_D)) ? sp : '0;
    end

    assign d_bus = (state == WR) ? data_r : 'z;

    // operand latch, pointer stepping, word capture and remaining-count tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp     <= '0;
            dp     <= '0;
            cnt    <= '0;
            data_r <= '0;
            back   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start && len != '0) begin
                    back <= bwd;
                    sp   <= bwd ? src + len - ADDR_W'(1) : src;
                    dp   <= bwd ? dst + len - ADDR_W'(1) : dst;
                    cnt  <= len;
                end
                RD_D: begin
                    data_r <= d_bus;
                    sp     <= sp + step;
                end
                WR: begin
                    dp  <= dp + step;
                    cnt <= cnt - ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_two_op_dma.sv
// tb_two_op_dma: table-driven copy checks plus reset, zero-length and address-order sequences
module tb_two_op_dma;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] src = '0, dst = '0, len = '0;
    logic        busy, done, bus_req, mem_read, mem_write;
    logic        bus_gnt = 1'b0;
    logic [15:0] d_addr;
    wire  [15:0] d_bus;

    two_op_dma dut (
        .clk(clk), .rst_n(rst_n), .start(start), .src(src), .dst(dst), .len(len),
        .busy(busy), .done(done), .bus_req(bus_req), .bus_gnt(bus_gnt),
        .mem_read(mem_read), .mem_write(mem_write), .d_addr(d_addr), .d_bus(d_bus)
    );

    always #5 clk = ~clk;

    // memory model: registered read, drives d_bus while mem_read is high
    logic [15:0] mem [0:65535];
    logic [15:0] rd_q = '0;
    logic        tb_we = 1'b0;
    logic [15:0] tb_addr = '0, tb_data = '0;
    assign d_bus = mem_read ? rd_q : 'z;
    always @(posedge clk) begin
        if (tb_we) mem[tb_addr] <= tb_data;
        else if (mem_write) mem[d_addr] <= d_bus;
        if (mem_read) rd_q <= mem[d_addr];
    end

    int tests = 0, fails = 0, excl = 0;

    // bus exclusivity watched over the whole run
    always @(negedge clk) begin
        if (mem_read && mem_write) excl++;
        if (!mem_read && !mem_write && d_bus !== 16'hzzzz) excl++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic poke(input logic [15:0] a, input logic [15:0] d);
        tb_addr = a;
        tb_data = d;
        tb_we   = 1'b1;
        @(negedge clk);
        tb_we   = 1'b0;
    endtask

    typedef struct packed {
        logic [15:0]      src;
        logic [15:0]      dst;
        logic [15:0]      len;
        int               gdly;
        bit               ign;
        logic [3:0][15:0] w;
        int               ecyc;
    } vec_t;

    function automatic vec_t mk(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                                input int g, input bit ig, input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] c, input logic [15:0] e, input int ec);
        mk.src  = s;
        mk.dst  = d;
        mk.len  = l;
        mk.gdly = g;
        mk.ign  = ig;
        mk.w    = {e, c, b, a};
        mk.ecyc = ec;
    endfunction

    logic [15:0] rd_log [0:15];
    logic [15:0] wr_log [0:15];
    int          rd_n, wr_n;

    // one copy: preload, start at a negedge, count edges until done, then verify memory
    task automatic run_vec(input vec_t v, input int id);
        int  edges, got;
        bit  quiet, busy_ok, prev_rd;
        for (int i = 0; i < int'(v.len); i++) poke(v.dst + 16'(i), 16'hDEAD);
        for (int i = 0; i < int'(v.len); i++) poke(v.src + 16'(i), v.w[i]);
        bus_gnt = (v.gdly == 0);
        rd_n = 0; wr_n = 0;
        src = v.src; dst = v.dst; len = v.len; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        edges = 0; got = -1; quiet = 1; busy_ok = 1; prev_rd = 0;
        while (edges < 60) begin
            if (mem_read && !prev_rd && rd_n < 16) begin rd_log[rd_n] = d_addr; rd_n++; end
            if (mem_write && wr_n < 16) begin wr_log[wr_n] = d_addr; wr_n++; end
            prev_rd = mem_read;
            if (edges <= v.gdly && (mem_read || mem_write)) quiet = 0;
            if (!busy) busy_ok = 0;
            if (done) begin got = edges; break; end
            if (v.ign && edges == 4) begin
                start = 1'b1; src = 16'h0010; dst = 16'h0900; len = 16'h0002;
            end else start = 1'b0;
            if (edges >= v.gdly) bus_gnt = 1'b1;
            @(negedge clk);
            edges++;
        end
        start = 1'b0;
        chk($sformatf("v%0d done_edge", id), got, v.ecyc);
        chk($sformatf("v%0d busy_through", id), busy_ok, 1);
        @(negedge clk);
        chk($sformatf("v%0d idle_after", id), {busy, done, bus_req}, 0);
        if (v.gdly > 0) chk($sformatf("v%0d quiet_no_grant", id), quiet, 1);
        for (int i = 0; i < int'(v.len); i++)
            chk($sformatf("v%0d dst[%0d]", id, i), mem[v.dst + 16'(i)], v.w[i]);
        bus_gnt = 1'b0;
    endtask

    vec_t vecs [8];

    initial begin
        int dn, br;
        vecs[0] = mk(16'h0010, 16'h0100, 4, 0, 0, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 13);
        vecs[1] = mk(16'h0020, 16'h0022, 4, 0, 0, 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD, 13);
        vecs[2] = mk(16'h0022, 16'h0020, 4, 0, 0, 16'h5555, 16'h6666, 16'h7777, 16'h8888, 13);
        vecs[3] = mk(16'hFFFE, 16'h0200, 4, 0, 0, 16'h9001, 16'h9002, 16'h9003, 16'h9004, 13);
        vecs[4] = mk(16'h0300, 16'h0310, 3, 5, 1, 16'h0A01, 16'h0A02, 16'h0A03, 16'h0000, 15);
        vecs[5] = mk(16'h0500, 16'h0500, 2, 0, 0, 16'h0B01, 16'h0B02, 16'h0000, 16'h0000, 7);
        vecs[6] = mk(16'h0600, 16'h05FF, 2, 0, 0, 16'h0C01, 16'h0C02, 16'h0000, 16'h0000, 7);
        vecs[7] = mk(16'h0700, 16'h0701, 1, 0, 0, 16'h0D01, 16'h0000, 16'h0000, 16'h0000, 4);

        repeat (2) @(negedge clk);
        chk("rst_outputs", {busy, done, bus_req, mem_read, mem_write}, 0);
        chk("rst_d_addr", d_addr, 0);
        chk("rst_d_bus_z", d_bus === 16'hzzzz, 1);
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 8; k++) begin
            run_vec(vecs[k], k);
            if (k == 1) begin
                chk("bwd_first_read", rd_log[0], 16'h0023);
                chk("bwd_first_write", wr_log[0], 16'h0025);
            end
            if (k == 3) begin
                chk("wrap_rd0", rd_log[0], 16'hFFFE);
                chk("wrap_rd1", rd_log[1], 16'hFFFF);
                chk("wrap_rd2", rd_log[2], 16'h0000);
                chk("wrap_rd3", rd_log[3], 16'h0001);
            end
            if (k == 4) chk("ignored_start_dst", mem[16'h0900] === 16'h0010 ? 0 : 1, 1);
        end

        // zero length: one done pulse, no bus request
        src = 16'h0010; dst = 16'h0100; len = 16'h0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dn = 0; br = 0;
        for (int i = 0; i < 4; i++) begin
            if (done) dn++;
            if (bus_req) br++;
            @(negedge clk);
        end
        chk("len0_done_pulses", dn, 1);
        chk("len0_bus_req", br, 0);
        chk("len0_idle", busy, 0);

        // reset during WR of word 2 of 4
        for (int i = 0; i < 4; i++) poke(16'h0410 + 16'(i), 16'hDEAD);
        for (int i = 0; i < 4; i++) poke(16'h0400 + 16'(i), 16'hC001 + 16'(i));
        bus_gnt = 1'b1;
        src = 16'h0400; dst = 16'h0410; len = 16'h0004; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        chk("mid_in_wr2", {mem_write, d_addr}, {1'b1, 16'h0411});
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outputs", {busy, done, bus_req, mem_read, mem_write}, 0);
        chk("mid_rst_d_addr", d_addr, 0);
        chk("mid_rst_d_bus_z", d_bus === 16'hzzzz, 1);
        @(negedge clk);
        rst_n = 1'b1;
        bus_gnt = 1'b0;
        @(negedge clk);
        chk("mid_word1_kept", mem[16'h0410], 16'hC001);
        chk("mid_word2_unwritten", mem[16'h0411], 16'hDEAD);
        run_vec(mk(16'h0400, 16'h0410, 4, 0, 0, 16'hC001, 16'hC002, 16'hC003, 16'hC004, 13), 8);

        chk("bus_exclusive", excl, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
